// File: rtl/ddr_dqs_rcvr_en_seq.sv
// Multi-channel DQS receiver enable sequencer.
// Each channel runs an IDLE -> WARM -> ACTIVE -> HOLD sequence so that the
// analog receiver is enabled early enough to settle (warm-up) and stays enabled
// through the read postamble (hold-off). A software override forces every
// channel's outputs for bring-up and calibration.
//
// Interface: i_ie is a level request per channel, not a handshake. While it is
// high the channel is, or is heading to, ACTIVE. o_rdy marks the cycles where
// DQS capture is valid. All per-channel outputs come straight from flops.
module ddr_dqs_rcvr_en_seq #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 6
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_CH-1:0]   i_ie,
  input  logic                i_sw_ovr,
  input  logic                i_sw_en,
  input  logic                i_edge_det_byp,
  input  logic [CNT_W-1:0]    i_warmup_cnt,
  input  logic [CNT_W-1:0]    i_hold_cnt,
  output logic [NUM_CH-1:0]   o_rcvr_ena,
  output logic [NUM_CH-1:0]   o_edge_det_ena,
  output logic [NUM_CH-1:0]   o_rdy,
  output logic                o_busy,
  output logic [2*NUM_CH-1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARM   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] rcvr_ena_d;
  logic [NUM_CH-1:0] edge_det_ena_d;
  logic [NUM_CH-1:0] rdy_d;
  logic              ovr_q;
  logic              hold_idle;

  // The FSMs stay parked in IDLE during override and for the first cycle after
  // it is released, so the outputs show one clean IDLE cycle before any new
  // warm-up starts.
  assign hold_idle = i_sw_ovr | ovr_q;

  // Next-state, counter update and output decode from the next state
  always_comb begin
    rcvr_ena_d     = '0;
    edge_det_ena_d = '0;
    rdy_d          = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      if (hold_idle) begin
        state_d[c] = ST_IDLE;
        cnt_d[c]   = '0;
      end else begin
        case (state_q[c])
          ST_IDLE: begin
            if (i_ie[c]) begin
              if (i_warmup_cnt != '0) begin
                state_d[c] = ST_WARM;
                cnt_d[c]   = i_warmup_cnt;
              end else begin
                state_d[c] = ST_ACTIVE;
              end
            end
          end
          ST_WARM: begin
            if (!i_ie[c]) begin
              state_d[c] = ST_IDLE;
              cnt_d[c]   = '0;
            end else if (cnt_q[c] <= CNT_W'(1)) begin
              state_d[c] = ST_ACTIVE;
              cnt_d[c]   = '0;
            end else begin
              cnt_d[c] = cnt_q[c] - CNT_W'(1);
            end
          end
          ST_ACTIVE: begin
            if (!i_ie[c]) begin
              if (i_hold_cnt != '0) begin
                state_d[c] = ST_HOLD;
                cnt_d[c]   = i_hold_cnt;
              end else begin
                state_d[c] = ST_IDLE;
              end
            end
          end
          ST_HOLD: begin
            if (i_ie[c]) begin
              state_d[c] = ST_ACTIVE;
              cnt_d[c]   = '0;
            end else if (cnt_q[c] <= CNT_W'(1)) begin
              state_d[c] = ST_IDLE;
              cnt_d[c]   = '0;
            end else begin
              cnt_d[c] = cnt_q[c] - CNT_W'(1);
            end
          end
          default: begin
            state_d[c] = ST_IDLE;
            cnt_d[c]   = '0;
          end
        endcase
      end

      case (state_d[c])
        ST_WARM: begin
          rcvr_ena_d[c]     = 1'b1;
          edge_det_ena_d[c] = i_edge_det_byp;
        end
        ST_ACTIVE: begin
          rcvr_ena_d[c]     = 1'b1;
          edge_det_ena_d[c] = 1'b1;
          rdy_d[c]          = 1'b1;
        end
        ST_HOLD: begin
          rcvr_ena_d[c]     = 1'b1;
          edge_det_ena_d[c] = 1'b1;
        end
        default: ;
      endcase
    end

    if (i_sw_ovr) begin
      rcvr_ena_d     = {NUM_CH{i_sw_en}};
      edge_det_ena_d = {NUM_CH{i_sw_en}};
      rdy_d          = {NUM_CH{i_sw_en}};
    end
  end

  // State, counter and output registers; reset clears outputs immediately
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= ST_IDLE;
        cnt_q[c]   <= '0;
      end
      ovr_q          <= 1'b0;
      o_rcvr_ena     <= '0;
      o_edge_det_ena <= '0;
      o_rdy          <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      ovr_q          <= i_sw_ovr;
      o_rcvr_ena     <= rcvr_ena_d;
      o_edge_det_ena <= edge_det_ena_d;
      o_rdy          <= rdy_d;
    end
  end

  assign o_busy = |o_rcvr_ena;

  // Flatten per-channel state for debug visibility
  always_comb begin
    o_dbg_state = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      o_dbg_state[2*c +: 2] = state_q[c];
    end
  end

endmodule

// File: tb/tb_ddr_dqs_rcvr_en_seq.sv
// Bench for the DQS receiver enable sequencer: directed timing scenarios plus
// randomized traffic compared against a cycle model built from the rules.
module tb_ddr_dqs_rcvr_en_seq;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 6;

  logic              clk;
  logic              rst_n;
  logic [NUM_CH-1:0] ie;
  logic              sw_ovr;
  logic              sw_en;
  logic              byp;
  logic [CNT_W-1:0]  warm;
  logic [CNT_W-1:0]  hold;
  logic [NUM_CH-1:0] rcvr_ena;
  logic [NUM_CH-1:0] edge_det_ena;
  logic [NUM_CH-1:0] rdy;
  logic              busy;
  logic [2*NUM_CH-1:0] dbg_state;

  int checks;
  int failures;

  ddr_dqs_rcvr_en_seq #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_ie           (ie),
    .i_sw_ovr       (sw_ovr),
    .i_sw_en        (sw_en),
    .i_edge_det_byp (byp),
    .i_warmup_cnt   (warm),
    .i_hold_cnt     (hold),
    .o_rcvr_ena     (rcvr_ena),
    .o_edge_det_ena (edge_det_ena),
    .o_rdy          (rdy),
    .o_busy         (busy),
    .o_dbg_state    (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per channel "powered", "settled", "draining" flags and a
  // remaining-cycle count, advanced once per rising edge from the rules.
  int              m_on     [NUM_CH];
  int              m_ready  [NUM_CH];
  int              m_drain  [NUM_CH];
  int              m_left   [NUM_CH];
  int              m_after_ovr;
  logic [NUM_CH-1:0] m_ena;
  logic [NUM_CH-1:0] m_ede;
  logic [NUM_CH-1:0] m_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || sw_ovr || m_after_ovr != 0) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_on[c] = 0; m_ready[c] = 0; m_drain[c] = 0; m_left[c] = 0;
      end
      if (rst_n && sw_ovr) begin
        m_ena = {NUM_CH{sw_en}}; m_ede = {NUM_CH{sw_en}}; m_rdy = {NUM_CH{sw_en}};
        m_after_ovr = 1;
      end else begin
        m_ena = '0; m_ede = '0; m_rdy = '0;
        m_after_ovr = 0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_on[c] == 0) begin
          if (ie[c]) begin
            m_on[c] = 1; m_left[c] = int'(warm); m_ready[c] = (warm == 0) ? 1 : 0;
          end
        end else if (m_ready[c] == 0) begin
          if (!ie[c]) m_on[c] = 0;
          else if (m_left[c] <= 1) m_ready[c] = 1;
          else m_left[c] = m_left[c] - 1;
        end else if (m_drain[c] == 0) begin
          if (!ie[c]) begin
            if (hold == 0) begin m_on[c] = 0; m_ready[c] = 0; end
            else begin m_drain[c] = 1; m_left[c] = int'(hold); end
          end
        end else begin
          if (ie[c]) m_drain[c] = 0;
          else if (m_left[c] <= 1) begin m_on[c] = 0; m_ready[c] = 0; m_drain[c] = 0; end
          else m_left[c] = m_left[c] - 1;
        end
        m_ena[c] = (m_on[c] != 0);
        m_rdy[c] = (m_on[c] != 0) && (m_ready[c] != 0) && (m_drain[c] == 0);
        m_ede[c] = (m_on[c] != 0) && ((m_ready[c] != 0) || byp);
      end
    end
  end

  // Driver: advance to the next falling edge (outputs of the last rising edge)
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    ie = '0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ie = '0; sw_ovr = 1'b0; sw_en = 1'b0; byp = 1'b0;
    warm = '0; hold = '0;
    repeat (3) tick();
    checks++;
    if ({rcvr_ena, edge_det_ena, rdy, busy, dbg_state} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got ena=%b ede=%b rdy=%b busy=%b st=%b expected all 0",
               rcvr_ena, edge_det_ena, rdy, busy, dbg_state);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if ({rcvr_ena, edge_det_ena, rdy, busy} !== '0) begin
      failures++;
      $display("FAIL reset_release_idle: got ena=%b ede=%b rdy=%b busy=%b expected all 0",
               rcvr_ena, edge_det_ena, rdy, busy);
    end
  endtask

  // W=3, H=2, ch0 request held for 8 sampled edges
  task automatic test_basic_timing();
    logic [2:0] exp0;
    logic [2:0] got0;
    warm = 6'd3; hold = 6'd2; byp = 1'b0;
    ie[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp0 = {(k >= 1 && k <= 10), (k >= 4 && k <= 10), (k >= 4 && k <= 8)};
      got0 = {rcvr_ena[0], edge_det_ena[0], rdy[0]};
      checks++;
      if (got0 !== exp0 || {rcvr_ena[1], edge_det_ena[1], rdy[1]} !== 3'b000 || busy !== exp0[2]) begin
        failures++;
        $display("FAIL basic_timing k=%0d: got ch0 ena/ede/rdy=%b ch1=%b%b%b busy=%b expected ch0=%b ch1=000",
                 k, got0, rcvr_ena[1], edge_det_ena[1], rdy[1], busy, exp0);
      end
      if (k == 8) ie[0] = 1'b0;
    end
  endtask

  task automatic test_zero_counts();
    logic [2:0] exp1;
    int first_rdy;
    warm = 6'd0; hold = 6'd0;
    ie[1] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp1 = (k <= 5) ? 3'b111 : 3'b000;
      checks++;
      if ({rcvr_ena[1], edge_det_ena[1], rdy[1]} !== exp1) begin
        failures++;
        $display("FAIL zero_counts k=%0d: got ch1=%b%b%b expected %b",
                 k, rcvr_ena[1], edge_det_ena[1], rdy[1], exp1);
      end
      if (k == 5) ie[1] = 1'b0;
    end
    // Maximum counts: no wrap, rdy exactly 64 cycles after the request
    warm = 6'd63; hold = 6'd63;
    ie[0] = 1'b1;
    first_rdy = 0;
    for (int k = 1; k <= 70; k++) begin
      tick();
      if (rdy[0] && first_rdy == 0) first_rdy = k;
    end
    checks++;
    if (first_rdy != 64) begin
      failures++;
      $display("FAIL max_warmup: rdy first at %0d cycles, expected 64", first_rdy);
    end
    ie[0] = 1'b0;
    for (int k = 1; k <= 65; k++) begin
      tick();
      if (k == 63 || k == 64) begin
        checks++;
        if (rcvr_ena[0] !== (k == 63)) begin
          failures++;
          $display("FAIL max_hold k=%0d: got ena=%b expected %b", k, rcvr_ena[0], (k == 63));
        end
      end
    end
  endtask

  task automatic test_abort_rearm();
    int saw_rdy;
    int ena_dropped;
    warm = 6'd5; hold = 6'd4;
    ie[0] = 1'b1;
    saw_rdy = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (rdy[0]) saw_rdy = 1;
      if (k == 3) begin
        checks++;
        if (rcvr_ena[0] !== 1'b0) begin
          failures++;
          $display("FAIL warm_abort: got ena=%b expected 0", rcvr_ena[0]);
        end
      end
      if (k == 2) ie[0] = 1'b0;
    end
    checks++;
    if (saw_rdy != 0) begin
      failures++;
      $display("FAIL abort_no_rdy: got rdy pulse=%0d expected 0", saw_rdy);
    end
    ie[0] = 1'b1;
    repeat (6) tick();
    ie[0] = 1'b0;
    ena_dropped = 0;
    for (int j = 1; j <= 5; j++) begin
      tick();
      if (!rcvr_ena[0]) ena_dropped = 1;
      checks++;
      if (rdy[0] !== (j >= 3)) begin
        failures++;
        $display("FAIL hold_rearm j=%0d: got rdy=%b expected %b", j, rdy[0], (j >= 3));
      end
      if (j == 2) ie[0] = 1'b1;
    end
    checks++;
    if (ena_dropped != 0) begin
      failures++;
      $display("FAIL hold_rearm_ena: got ena drop=%0d expected 0", ena_dropped);
    end
    idle_cycles(8);
  endtask

  task automatic test_edge_det_bypass();
    logic [1:0] exp_er;
    for (int pass = 0; pass < 2; pass++) begin
      byp = (pass == 0);
      warm = 6'd4; hold = 6'd1;
      ie[1] = 1'b1;
      for (int k = 1; k <= 5; k++) begin
        tick();
        exp_er = {(k == 5) || byp, (k == 5)};
        checks++;
        if (rcvr_ena[1] !== 1'b1 || {edge_det_ena[1], rdy[1]} !== exp_er) begin
          failures++;
          $display("FAIL edge_det_byp=%0d k=%0d: got ena=%b ede/rdy=%b%b expected ena=1 ede/rdy=%b",
                   byp, k, rcvr_ena[1], edge_det_ena[1], rdy[1], exp_er);
        end
      end
      idle_cycles(4);
    end
    byp = 1'b0;
  endtask

  task automatic test_override();
    warm = 6'd3; hold = 6'd2;
    ie[0] = 1'b1;
    tick();
    sw_ovr = 1'b1; sw_en = 1'b1;
    tick();
    checks++;
    if ({rcvr_ena, edge_det_ena, rdy, busy} !== 7'h7f) begin
      failures++;
      $display("FAIL override_on: got ena=%b ede=%b rdy=%b busy=%b expected all 1",
               rcvr_ena, edge_det_ena, rdy, busy);
    end
    sw_en = 1'b0;
    tick();
    checks++;
    if ({rcvr_ena, edge_det_ena, rdy, busy} !== 7'h00) begin
      failures++;
      $display("FAIL override_en0: got ena=%b ede=%b rdy=%b busy=%b expected all 0",
               rcvr_ena, edge_det_ena, rdy, busy);
    end
    sw_en = 1'b1;
    tick();
    sw_ovr = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++;
      if (rcvr_ena[0] !== (k >= 2) || rdy[0] !== (k >= 5) || rcvr_ena[1] !== 1'b0) begin
        failures++;
        $display("FAIL override_release k=%0d: got ena=%b rdy=%b expected ena=%b rdy=%b",
                 k, rcvr_ena, rdy, {1'b0, (k >= 2)}, {1'b0, (k >= 5)});
      end
    end
    sw_en = 1'b0;
    idle_cycles(5);
  endtask

  task automatic test_async_reset();
    warm = 6'd2; hold = 6'd3;
    ie = 2'b11;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rcvr_ena, edge_det_ena, rdy, busy} !== 7'h00) begin
      failures++;
      $display("FAIL async_reset: got ena=%b ede=%b rdy=%b busy=%b expected all 0",
               rcvr_ena, edge_det_ena, rdy, busy);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (rcvr_ena !== 2'b11 || rdy !== {2{(k >= 3)}}) begin
        failures++;
        $display("FAIL reset_restart k=%0d: got ena=%b rdy=%b expected ena=11 rdy=%b",
                 k, rcvr_ena, rdy, {2{(k >= 3)}});
      end
    end
    idle_cycles(6);
  endtask

  task automatic test_random();
    int ovr_left;
    ovr_left = 0;
    for (int n = 0; n < 600; n++) begin
      tick();
      checks++;
      if (rcvr_ena !== m_ena || edge_det_ena !== m_ede || rdy !== m_rdy || busy !== (|m_ena)) begin
        failures++;
        $display("FAIL random n=%0d: got ena=%b ede=%b rdy=%b busy=%b expected ena=%b ede=%b rdy=%b",
                 n, rcvr_ena, edge_det_ena, rdy, busy, m_ena, m_ede, m_rdy);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 5) == 0) ie[c] = ~ie[c];
      end
      if ($urandom_range(0, 15) == 0) warm = CNT_W'($urandom_range(0, 6));
      if ($urandom_range(0, 15) == 0) hold = CNT_W'($urandom_range(0, 6));
      if ($urandom_range(0, 9) == 0) byp = ~byp;
      if (ovr_left > 0) begin
        ovr_left--;
        if (ovr_left == 0) sw_ovr = 1'b0;
      end else if ($urandom_range(0, 49) == 0) begin
        sw_ovr = 1'b1;
        sw_en = 1'($urandom_range(0, 1));
        ovr_left = $urandom_range(1, 3);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic_timing();
    test_zero_counts();
    test_abort_rearm();
    test_edge_det_bypass();
    test_override();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ddr_dqs_rcvr_en_seq.md
Name: ddr_dqs_rcvr_en_seq

Overview:
- Multi-channel DQS receiver enable sequencer. It sits between the DFI/IO read-enable logic and the DQS receiver analog macros.
- Replaces the purely combinational enable OR/mux with a timed per-channel FSM: warm-up before ready, edge-detect arming after warm-up, and postamble hold-off before disable.
- Keeps a software override path for bring-up and calibration.

Parameters:
- NUM_CH, 2, number of independent DQS receiver channels (one FSM each).
- CNT_W, 6, width of the warm-up and hold-off counters and their config inputs.

Ports:
- i_clk  input  1  PHY core clock; all state on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_ie  input  NUM_CH  per-channel receive-enable request, synchronous to i_clk.
- i_sw_ovr  input  1  software override select, common to all channels.
- i_sw_en  input  1  software enable value used while i_sw_ovr=1.
- i_edge_det_byp  input  1  1: edge-detect enable follows receiver enable, no gating during warm-up.
- i_warmup_cnt  input  CNT_W  warm-up cycles W before ready.
- i_hold_cnt  input  CNT_W  hold-off cycles H after request drop.
- o_rcvr_ena  output  NUM_CH  receiver enable to analog macro (d_ena).
- o_edge_det_ena  output  NUM_CH  edge detector enable (d_edge_det_ena).
- o_rdy  output  NUM_CH  receiver settled, DQS valid for capture.
- o_busy  output  1  OR-reduce of o_rcvr_ena.

Behaviour:
- Reset: every FSM goes to IDLE and counters clear. o_rcvr_ena, o_edge_det_ena and o_rdy are 0; o_busy is 0.
- All per-channel outputs are registered and decoded from the next-state. There is no combinational path from any input to any output except o_busy, which is derived from o_rcvr_ena.
- Per-channel FSM states: IDLE, WARM, ACTIVE, HOLD.
- Output encoding by state (rcvr_ena / edge_det_ena / rdy):
  - IDLE: 0/0/0
  - WARM: 1/i_edge_det_byp/0
  - ACTIVE: 1/1/1
  - HOLD: 1/1/0
- IDLE:
  - i_ie sampled 1 with W>0: go to WARM and load cnt=W.
  - i_ie sampled 1 with W=0: go directly to ACTIVE.
- WARM:
  - i_ie=0: go to IDLE (abort; no rdy pulse; no hold-off).
  - Else if cnt<=1: go to ACTIVE.
  - Else: cnt decrements by 1.
- ACTIVE:
  - i_ie=0 with H>0: go to HOLD and load cnt=H.
  - i_ie=0 with H=0: go to IDLE.
- HOLD:
  - i_ie=1: go to ACTIVE with no re-warm-up; rdy reasserts next cycle.
  - Else if cnt<=1: go to IDLE.
  - Else: cnt decrements by 1.
- Latency for i_ie rising sampled at edge N:
  - o_rcvr_ena=1 from N+1.
  - o_rdy=1 from N+1+W.
  - o_edge_det_ena from N+1+W, or from N+1 if byp=1.
- Latency for i_ie falling sampled at edge M in ACTIVE:
  - o_rdy=0 from M+1.
  - o_rcvr_ena=0 from M+1+H.
- Counter width: cnt is CNT_W bits. W and H are sampled only at load; changes mid-count have no effect until the next load. The maximum value 2^CNT_W-1 is supported with no wrap.
- Software override:
  - While i_sw_ovr=1, all FSMs are held in IDLE and counters clear.
  - Registered outputs are forced to o_rcvr_ena=o_edge_det_ena=o_rdy={NUM_CH{i_sw_en}}, taking effect one cycle after i_sw_ovr/i_sw_en are sampled.
  - On i_sw_ovr falling, outputs return to FSM values the next cycle (IDLE → 0). A channel with i_ie=1 then goes to WARM and takes the full warm-up.
- Channels are fully independent; simultaneous transitions on different channels do not interact.
- Asynchronous reset mid-sequence: every output drops to 0 immediately, without waiting for a clock edge. The first cycle after release is IDLE.

Test Plan:
- Reset and basic timing: reset, W=3, H=2, pulse i_ie[0]=1 at edge 10 for 8 cycles -> rcvr_ena[0]=1 from edge 11, rdy[0] and edge_det_ena[0]=1 from edge 14; after i_ie drop sampled at edge 18, rdy[0]=0 at 19 and rcvr_ena[0]=0 at 21. Channel 1 outputs stay 0 throughout.
- Zero counts: W=0, H=0 -> rdy asserts the cycle after i_ie rises and rcvr_ena drops the cycle after i_ie falls. Then W=63, H=63 -> rdy exactly 64 cycles after i_ie is sampled high, with no counter wrap.
- Abort and re-arm: W=5, drop i_ie after 2 WARM cycles -> IDLE next cycle and rdy never pulses. H=4, reassert i_ie in the 2nd HOLD cycle -> ACTIVE next cycle, rdy back with no warm-up, rcvr_ena never drops.
- Edge-detect bypass: i_edge_det_byp=1, W=4 -> edge_det_ena asserts together with rcvr_ena, 4 cycles before rdy. With byp=0, edge_det_ena asserts together with rdy.
- Override: i_sw_ovr=1 with i_sw_en=1 mid-WARM on channel 0 -> all outputs on both channels are 1 the next cycle. Release with i_ie[0]=1 -> outputs 0 for one cycle, then full W-cycle warm-up.
- Async reset mid-ACTIVE: assert i_rst_n=0 between clock edges -> all outputs and o_busy are 0 immediately. After release with i_ie=1, the sequence restarts from IDLE.
